// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Core clock-enable sequencer: halt, full-speed, divided-rate and
//               single-step execution, plus a core halt latch and cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int CLK_HZ      = 16_000_000,
    parameter int DIV_WIDTH   = 24,
    parameter int DEFAULT_DIV = 800_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_mode,
    input  logic                 i_div_wr,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_step,
    input  logic                 i_halt_req,
    input  logic                 i_resume,
    output logic                 o_cpu_en,
    output logic                 o_running,
    output logic                 o_halted,
    output logic [31:0]          o_cycle_count,
    output logic                 o_heartbeat
);

    // A non-positive default divider falls back to a 20 Hz rate.
    localparam logic [DIV_WIDTH-1:0] c_reset_div = (DEFAULT_DIV > 0) ?
        DIV_WIDTH'(DEFAULT_DIV) : DIV_WIDTH'(CLK_HZ / 20);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_FULL = 2'd1,
        S_RUN_DIV  = 2'd2,
        S_STEP     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] w_div_last;
    logic                 step_prev_q;
    logic                 pend_q, pend_d;
    logic                 halt_q, halt_d;
    logic                 en_q, en_d;
    logic                 hb_q;
    logic [31:0]          count_q;

    assign w_div_last = (div_q <= DIV_WIDTH'(1)) ? '0 : div_q - DIV_WIDTH'(1);

    always_comb begin
        halt_d  = i_halt_req | (halt_q & ~i_resume);
        state_d = S_IDLE;
        div_d   = i_div_wr ? i_div : div_q;
        cnt_d   = '0;
        en_d    = 1'b0;
        pend_d  = 1'b0;

        // Using the next halt value lets a resume restart the state one cycle earlier.
        if (!halt_d) begin
            case (i_mode)
                2'd1:    state_d = S_RUN_FULL;
                2'd2:    state_d = S_RUN_DIV;
                2'd3:    state_d = S_STEP;
                default: state_d = S_IDLE;
            endcase
        end

        if (!i_div_wr && (state_q == S_RUN_DIV) && (cnt_q < w_div_last))
            cnt_d = cnt_q + DIV_WIDTH'(1);

        case (state_q)
            S_RUN_FULL: en_d = 1'b1;
            S_RUN_DIV:  en_d = (cnt_q >= w_div_last);
            S_STEP:     en_d = pend_q;
            default:    en_d = 1'b0;
        endcase
        if (i_halt_req)
            en_d = 1'b0;

        // A pending step is consumed by its pulse; edges seen while pending are dropped.
        if (state_d == S_STEP) begin
            if ((state_q == S_STEP) && pend_q)
                pend_d = 1'b0;
            else
                pend_d = pend_q | (i_step & ~step_prev_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            div_q       <= c_reset_div;
            cnt_q       <= '0;
            step_prev_q <= 1'b0;
            pend_q      <= 1'b0;
            halt_q      <= 1'b0;
            en_q        <= 1'b0;
            hb_q        <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            step_prev_q <= i_step;
            pend_q      <= pend_d;
            halt_q      <= halt_d;
            en_q        <= en_d;
            if (en_q) begin
                hb_q    <= ~hb_q;
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign o_cpu_en      = en_q;
    assign o_running     = (state_q == S_RUN_FULL) || (state_q == S_RUN_DIV);
    assign o_halted      = halt_q;
    assign o_cycle_count = count_q;
    assign o_heartbeat   = hb_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Scoreboard bench for cpu_run_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int DW      = 24;
    localparam int DEF_DIV = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic          div_wr = 1'b0;
    logic [DW-1:0] div = '0;
    logic          step = 1'b0;
    logic          halt_req = 1'b0;
    logic          resume = 1'b0;
    logic          cpu_en, running, halted, heartbeat;
    logic [31:0]   cycle_count;

    cpu_run_ctrl #(
        .CLK_HZ      (16_000_000),
        .DIV_WIDTH   (DW),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mode        (mode),
        .i_div_wr      (div_wr),
        .i_div         (div),
        .i_step        (step),
        .i_halt_req    (halt_req),
        .i_resume      (resume),
        .o_cpu_en      (cpu_en),
        .o_running     (running),
        .o_halted      (halted),
        .o_cycle_count (cycle_count),
        .o_heartbeat   (heartbeat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        running;
        logic        halted;
        logic [31:0] count;
        logic        hb;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: mode in effect (0 when halted), cycles since divided-run start.
    int          m_mode;
    bit          m_halt, m_prev, m_pend, m_en, m_hb;
    longint      m_age, m_div;
    logic [31:0] m_count;

    task automatic model_reset();
        m_mode = 0; m_halt = 0; m_prev = 0; m_pend = 0; m_en = 0; m_hb = 0;
        m_age = 0; m_div = DEF_DIV; m_count = 32'd0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle of inputs at the current negedge and queues the expected result.
    task automatic cycle(input logic [1:0] md, input bit dw, input int unsigned dv,
                         input bit st, input bit hr, input bit rs);
        longint de;
        bit     en_n, halt_n, pend_n;
        int     mode_n;
        exp_t   e;
        mode = md; div_wr = dw; div = DW'(dv); step = st; halt_req = hr; resume = rs;

        de     = (m_div <= 1) ? 1 : m_div;
        en_n   = !hr && ((m_mode == 1) ||
                         (m_mode == 2 && (m_age % de) == de - 1) ||
                         (m_mode == 3 && m_pend));
        halt_n = hr || (m_halt && !rs);
        mode_n = halt_n ? 0 : int'(md);
        if (mode_n != 3)                pend_n = 0;
        else if (m_mode == 3 && m_pend) pend_n = 0;
        else                            pend_n = m_pend || (st && !m_prev);

        m_age   = (dw || m_mode != 2) ? 0 : m_age + 1;
        if (dw) m_div = longint'(dv % (1 << DW));
        m_count = m_count + (m_en ? 32'd1 : 32'd0);
        m_hb    = m_hb ^ m_en;
        m_en    = en_n;
        m_halt  = halt_n;
        m_mode  = mode_n;
        m_pend  = pend_n;
        m_prev  = st;

        e.en = m_en; e.running = (m_mode == 1 || m_mode == 2); e.halted = m_halt;
        e.count = m_count; e.hb = m_hb;
        sb_q.push_back(e);
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_count"}, cycle_count, 32'd0);
        check({tag, "_heartbeat"}, 32'(heartbeat), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty actual=0 required>=1 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("cpu_en", 32'(cpu_en), 32'(e.en));
                    check("running", 32'(running), 32'(e.running));
                    check("halted", 32'(halted), 32'(e.halted));
                    check("cycle_count", cycle_count, e.count);
                    check("heartbeat", 32'(heartbeat), 32'(e.hb));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        repeat (10) cycle(2'd1, 0, 0, 0, 0, 0);
        repeat (3)  cycle(2'd0, 0, 0, 0, 0, 0);
        cycle(2'd0, 1, 4, 0, 0, 0);
        repeat (20) cycle(2'd2, 0, 0, 0, 0, 0);
        repeat (2)  cycle(2'd0, 0, 0, 0, 0, 0);
        cycle(2'd0, 1, 0, 0, 0, 0);
        repeat (10) cycle(2'd2, 0, 0, 0, 0, 0);
        repeat (2)  cycle(2'd0, 0, 0, 0, 0, 0);

        repeat (5) cycle(2'd3, 0, 0, 0, 0, 0);
        cycle(2'd3, 0, 0, 1, 0, 0);
        cycle(2'd3, 0, 0, 0, 0, 0);
        cycle(2'd3, 0, 0, 1, 0, 0);
        cycle(2'd3, 0, 0, 0, 0, 0);
        cycle(2'd3, 0, 0, 1, 0, 0);
        repeat (6) cycle(2'd3, 0, 0, 1, 0, 0);
        repeat (3) cycle(2'd3, 0, 0, 0, 0, 0);

        repeat (6) cycle(2'd1, 0, 0, 0, 0, 0);
        cycle(2'd1, 0, 0, 0, 1, 0);
        repeat (3) cycle(2'd1, 0, 0, 0, 0, 0);
        cycle(2'd1, 0, 0, 0, 1, 1);
        repeat (3) cycle(2'd1, 0, 0, 0, 0, 0);
        cycle(2'd1, 0, 0, 0, 0, 1);
        repeat (5) cycle(2'd1, 0, 0, 0, 0, 0);

        begin
            logic [1:0] md;
            bit st;
            md = 2'd1; st = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) st = ~st;
                cycle(md, $urandom_range(0, 39) == 0, $urandom_range(0, 6), st,
                      $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0);
            end
        end

        // Reset asynchronously mid divided run with the divider counter at 2.
        cycle(2'd0, 1, 4, 0, 0, 0);
        repeat (3) cycle(2'd2, 0, 0, 0, 0, 0);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        mode = 2'd0; div_wr = 0; div = '0; step = 0; halt_req = 0; resume = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (22) cycle(2'd2, 0, 0, 0, 0, 0);

        begin
            logic [1:0] md;
            md = 2'd2;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
                cycle(md, $urandom_range(0, 29) == 0, $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
                      $urandom_range(0, 5) == 0);
            end
        end

        mon_en = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
